// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: register map, FSM states,
// vector/cause word layout and helpers that build those words.
package interrupt_controller_pkg;

    localparam int unsigned NSRC_C      = 8;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned VBASE_W     = 16;
    localparam int unsigned VEC_PAD_W   = 11;
    localparam int unsigned CAUSE_PAD_W = 5;

    localparam logic [31:0] ADDR_MASK   = 32'hFFFF_1010;
    localparam logic [31:0] ADDR_VBASE  = 32'hFFFF_1011;
    localparam logic [31:0] ADDR_PEND   = 32'hFFFF_1012;
    localparam logic [31:0] ADDR_SWTRIG = 32'hFFFF_1013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } intc_state_e;

    function automatic logic [31:0] vec_addr(input logic [VBASE_W-1:0] vbase,
                                             input logic [IDX_W-1:0]   idx);
        return {vbase, {VEC_PAD_W{1'b0}}, idx, 2'b00};
    endfunction

    function automatic logic [15:0] vec_data(input logic [IDX_W-1:0]  idx,
                                             input logic [NSRC_C-1:0] snap);
        return {{CAUSE_PAD_W{1'b0}}, idx, snap};
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Bus bundle between the interrupt controller (slave) and the CPU/source side (master).
interface interrupt_controller_if;

    logic [7:0]  src;
    logic        irq;
    logic        turnOffIRQ;
    logic [31:0] intAddr;
    logic [15:0] intData;
    logic [31:0] memAddr;
    logic [15:0] memWrite;
    logic        memWE;
    logic [15:0] regRead;
    logic        regHit;

    modport slave (
        input  src, turnOffIRQ, memAddr, memWrite, memWE,
        output irq, intAddr, intData, regRead, regHit
    );

    modport master (
        output src, turnOffIRQ, memAddr, memWrite, memWE,
        input  irq, intAddr, intData, regRead, regHit
    );

endinterface

// File: rtl/interrupt_controller_prio_enc.sv
// Combinational priority encoder: index of the lowest set request bit plus valid.
module intc_prio_enc
    import interrupt_controller_pkg::*;
(
    input  logic [NSRC_C-1:0] req_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < NSRC_C; i++) begin
            if (req_i[i] && !valid_o) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered 8-source interrupt controller with MASK/VBASE registers and IDLE/REQ/ACK handshake.
// Optional software trigger register at FFFF1013 enabled by defining INTC_SWTRIG_EN.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned NSRC = 8
) (
    input logic                   clk,
    input logic                   rst,
    interrupt_controller_if.slave bus
);

    intc_state_e       state_q, state_d;
    logic [NSRC-1:0]   src_prev_q;
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   mask_q;
    logic [VBASE_W-1:0] vbase_q;
    logic [IDX_W-1:0]  sel_q;
    logic [NSRC-1:0]   snap_q;
    logic [31:0]       int_addr_q;
    logic [15:0]       int_data_q;

    logic [NSRC-1:0]   req_masked;
    logic [NSRC-1:0]   rise;
    logic [NSRC-1:0]   sw_set;
    logic [NSRC-1:0]   clr_vec;
    logic [IDX_W-1:0]  win_idx;
    logic              win_valid;
    logic              latch_en;
    logic              wr_mask;
    logic              wr_vbase;
    logic              reg_hit;
    logic [15:0]       reg_rdata;

    assign req_masked = pending_q & mask_q;
    assign rise       = bus.src & ~src_prev_q;
    assign wr_mask    = bus.memWE && (bus.memAddr == ADDR_MASK);
    assign wr_vbase   = bus.memWE && (bus.memAddr == ADDR_VBASE);

    intc_prio_enc u_prio (
        .req_i   (req_masked),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

`ifdef INTC_SWTRIG_EN
    assign sw_set = (bus.memWE && (bus.memAddr == ADDR_SWTRIG)) ? bus.memWrite[NSRC-1:0] : '0;
`else
    assign sw_set = '0;
`endif

    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        clr_vec  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    latch_en = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.turnOffIRQ) begin
                    clr_vec[sel_q] = 1'b1;
                    state_d        = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // New edges and software sets are ORed after the clear so a set always wins.
    assign pending_d = (pending_q & ~clr_vec) | rise | sw_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_prev_q <= bus.src;
            pending_q  <= '0;
            mask_q     <= '0;
            vbase_q    <= '0;
            sel_q      <= '0;
            snap_q     <= '0;
            int_addr_q <= '0;
            int_data_q <= '0;
        end else begin
            src_prev_q <= bus.src;
            pending_q  <= pending_d;
            if (wr_mask) begin
                mask_q <= bus.memWrite[NSRC-1:0];
            end
            if (wr_vbase) begin
                vbase_q <= bus.memWrite;
            end
            // Vector and cause words are frozen here so later register writes cannot disturb REQ.
            if (latch_en) begin
                sel_q      <= win_idx;
                snap_q     <= pending_q;
                int_addr_q <= vec_addr(vbase_q, win_idx);
                int_data_q <= vec_data(win_idx, pending_q);
            end
        end
    end

    always_comb begin
        reg_hit   = 1'b0;
        reg_rdata = '0;
        case (bus.memAddr)
            ADDR_MASK: begin
                reg_hit   = 1'b1;
                reg_rdata = 16'(mask_q);
            end
            ADDR_VBASE: begin
                reg_hit   = 1'b1;
                reg_rdata = vbase_q;
            end
            ADDR_PEND: begin
                reg_hit   = 1'b1;
                reg_rdata = 16'(pending_q);
            end
`ifdef INTC_SWTRIG_EN
            ADDR_SWTRIG: begin
                reg_hit   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.irq     = (state_q == ST_REQ);
    assign bus.intAddr = int_addr_q;
    assign bus.intData = int_data_q;
    assign bus.regRead = reg_rdata;
    assign bus.regHit  = reg_hit;

    logic unused_snap;
    assign unused_snap = ^snap_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus a randomized run
// against a cycle-level behavioural model of pending bits and the request/ack service cycle.
module tb_interrupt_controller;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    interrupt_controller_if bus ();

    interrupt_controller #(.NSRC(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: service phase 0=waiting, 1=requesting, 2=cool-down.
    int          m_phase;
    int          m_sel;
    logic [7:0]  m_pend;
    logic [7:0]  m_mask;
    logic [7:0]  m_prev;
    logic [15:0] m_vbase;
    logic [31:0] m_intaddr;
    logic [15:0] m_intdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [31:0] a, output logic [15:0] d, output logic h);
        bus.memAddr = a;
        #1;
        d = bus.regRead;
        h = bus.regHit;
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [15:0] d);
        bus.memAddr  = a;
        bus.memWrite = d;
        bus.memWE    = 1'b1;
        tick();
        bus.memWE    = 1'b0;
        bus.memWrite = '0;
    endtask

    task automatic ack_and_drain();
        bus.turnOffIRQ = 1'b1;
        tick();
        bus.turnOffIRQ = 1'b0;
        tick();
        bus.src = '0;
        tick();
    endtask

    task automatic model_reset(input logic [7:0] s);
        m_phase   = 0;
        m_sel     = 0;
        m_pend    = '0;
        m_mask    = '0;
        m_prev    = s;
        m_vbase   = '0;
        m_intaddr = '0;
        m_intdata = '0;
    endtask

    task automatic model_step(input logic [7:0] s, input logic ack, input logic we,
                              input logic [31:0] a, input logic [15:0] wd);
        logic [7:0] rises;
        logic [7:0] sw;
        logic [7:0] granted;
        int         winner;
        int         next_phase;
        rises      = s & ~m_prev;
        sw         = '0;
`ifdef INTC_SWTRIG_EN
        if (we && a == 32'hFFFF1013) sw = wd[7:0];
`endif
        granted    = m_pend & m_mask;
        next_phase = m_phase;
        if (m_phase == 0) begin
            winner = -1;
            for (int i = 7; i >= 0; i--) if (granted[i]) winner = i;
            if (winner >= 0) begin
                m_sel      = winner;
                m_intaddr  = {m_vbase, 16'h0000} + 32'(winner * 4);
                m_intdata  = 16'(winner * 256) + 16'(m_pend);
                next_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (ack) begin
                m_pend[m_sel] = 1'b0;
                next_phase    = 2;
            end
        end else begin
            next_phase = 0;
        end
        m_pend = m_pend | rises | sw;
        if (we && a == 32'hFFFF1010) m_mask = wd[7:0];
        if (we && a == 32'hFFFF1011) m_vbase = wd;
        m_prev  = s;
        m_phase = next_phase;
    endtask

    function automatic logic [15:0] m_read(input logic [31:0] a);
        if (a == 32'hFFFF1010) return {8'h00, m_mask};
        if (a == 32'hFFFF1011) return m_vbase;
        if (a == 32'hFFFF1012) return {8'h00, m_pend};
        return 16'h0000;
    endfunction

    function automatic logic m_hit(input logic [31:0] a);
`ifdef INTC_SWTRIG_EN
        return (a >= 32'hFFFF1010) && (a <= 32'hFFFF1013);
`else
        return (a >= 32'hFFFF1010) && (a <= 32'hFFFF1012);
`endif
    endfunction

    task automatic test_reset();
        logic [15:0] d;
        logic        h;
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", bus.irq); else n_pass++;
        n_checks++; if (bus.intAddr !== 32'h0) $display("FAIL reset_intAddr: got %h expected 0", bus.intAddr); else n_pass++;
        n_checks++; if (bus.intData !== 16'h0) $display("FAIL reset_intData: got %h expected 0", bus.intData); else n_pass++;
        rst = 1'b0;
        tick();
        peek(32'hFFFF1010, d, h);
        n_checks++; if (d !== 16'h0 || h !== 1'b1) $display("FAIL reset_mask: got %h/%b expected 0000/1", d, h); else n_pass++;
        peek(32'hFFFF1011, d, h);
        n_checks++; if (d !== 16'h0 || h !== 1'b1) $display("FAIL reset_vbase: got %h/%b expected 0000/1", d, h); else n_pass++;
        peek(32'hFFFF1012, d, h);
        n_checks++; if (d !== 16'h0 || h !== 1'b1) $display("FAIL reset_pend: got %h/%b expected 0000/1", d, h); else n_pass++;
        peek(32'h0000_1010, d, h);
        n_checks++; if (d !== 16'h0 || h !== 1'b0) $display("FAIL nodecode: got %h/%b expected 0000/0", d, h); else n_pass++;
    endtask

    task automatic test_basic();
        logic [15:0] d;
        logic        h;
        write_reg(32'hFFFF1010, 16'h00FF);
        write_reg(32'hFFFF1011, 16'h4000);
        bus.src = 8'h04;
        tick();
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL basic_lat1: got irq %b expected 0", bus.irq); else n_pass++;
        tick();
        n_checks++; if (bus.irq !== 1'b1) $display("FAIL basic_irq: got %b expected 1", bus.irq); else n_pass++;
        n_checks++; if (bus.intAddr !== 32'h40000008) $display("FAIL basic_intAddr: got %h expected 40000008", bus.intAddr); else n_pass++;
        n_checks++; if (bus.intData !== 16'h0204) $display("FAIL basic_intData: got %h expected 0204", bus.intData); else n_pass++;
        bus.turnOffIRQ = 1'b1;
        tick();
        bus.turnOffIRQ = 1'b0;
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL basic_ack_irq: got %b expected 0", bus.irq); else n_pass++;
        tick();
        peek(32'hFFFF1012, d, h);
        n_checks++; if (d !== 16'h0000) $display("FAIL basic_pend_clear: got %h expected 0000", d); else n_pass++;
        n_checks++; if (bus.intAddr !== 32'h40000008) $display("FAIL basic_hold: got %h expected 40000008", bus.intAddr); else n_pass++;
        bus.src = '0;
        tick();
    endtask

    task automatic test_simultaneous();
        bus.src = 8'h22;
        tick();
        tick();
        n_checks++; if (bus.intData !== 16'h0122) $display("FAIL simul_first: got %h expected 0122", bus.intData); else n_pass++;
        n_checks++; if (bus.intAddr !== 32'h40000004) $display("FAIL simul_first_addr: got %h expected 40000004", bus.intAddr); else n_pass++;
        bus.turnOffIRQ = 1'b1;
        tick();
        bus.turnOffIRQ = 1'b0;
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL simul_ack: got irq %b expected 0", bus.irq); else n_pass++;
        tick();
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL simul_gap: got irq %b expected 0", bus.irq); else n_pass++;
        tick();
        n_checks++; if (bus.irq !== 1'b1) $display("FAIL simul_second_irq: got %b expected 1", bus.irq); else n_pass++;
        n_checks++; if (bus.intData !== 16'h0520) $display("FAIL simul_second: got %h expected 0520", bus.intData); else n_pass++;
        ack_and_drain();
    endtask

    task automatic test_mask();
        logic [15:0] d;
        logic        h;
        write_reg(32'hFFFF1010, 16'h0000);
        bus.src = 8'h08;
        tick();
        tick();
        tick();
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL mask_blocks: got irq %b expected 0", bus.irq); else n_pass++;
        peek(32'hFFFF1012, d, h);
        n_checks++; if (d !== 16'h0008) $display("FAIL mask_pend: got %h expected 0008", d); else n_pass++;
        write_reg(32'hFFFF1010, 16'h0008);
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL mask_lat1: got irq %b expected 0", bus.irq); else n_pass++;
        tick();
        n_checks++; if (bus.irq !== 1'b1) $display("FAIL mask_unmask_irq: got %b expected 1", bus.irq); else n_pass++;
        n_checks++; if (bus.intData !== 16'h0308) $display("FAIL mask_intData: got %h expected 0308", bus.intData); else n_pass++;
        ack_and_drain();
    endtask

    task automatic test_ack_rules();
        logic [15:0] d;
        logic        h;
        write_reg(32'hFFFF1010, 16'h00FF);
        bus.turnOffIRQ = 1'b1;
        tick();
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL idle_ack_irq: got %b expected 0", bus.irq); else n_pass++;
        bus.src = 8'h40;
        tick();
        peek(32'hFFFF1012, d, h);
        n_checks++; if (d !== 16'h0040) $display("FAIL idle_ack_pend: got %h expected 0040", d); else n_pass++;
        bus.turnOffIRQ = 1'b0;
        tick();
        n_checks++; if (bus.irq !== 1'b1 || bus.intData !== 16'h0640) $display("FAIL idle_ack_req: got %b/%h expected 1/0640", bus.irq, bus.intData); else n_pass++;
        bus.src = 8'h00;
        tick();
        n_checks++; if (bus.irq !== 1'b1) $display("FAIL req_hold: got irq %b expected 1", bus.irq); else n_pass++;
        bus.src = 8'h40;
        bus.turnOffIRQ = 1'b1;
        tick();
        peek(32'hFFFF1012, d, h);
        n_checks++; if (d !== 16'h0040) $display("FAIL set_over_clear: got %h expected 0040", d); else n_pass++;
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL set_over_clear_ack: got irq %b expected 0", bus.irq); else n_pass++;
        tick();
        bus.turnOffIRQ = 1'b0;
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL ack_ignore: got irq %b expected 0", bus.irq); else n_pass++;
        tick();
        n_checks++; if (bus.irq !== 1'b1 || bus.intData !== 16'h0640) $display("FAIL rerequest: got %b/%h expected 1/0640", bus.irq, bus.intData); else n_pass++;
        ack_and_drain();
    endtask

    task automatic test_reset_abort();
        logic [15:0] d;
        logic        h;
        bus.src = 8'h03;
        tick();
        tick();
        n_checks++; if (bus.irq !== 1'b1 || bus.intData !== 16'h0003) $display("FAIL abort_pre: got %b/%h expected 1/0003", bus.irq, bus.intData); else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL abort_irq: got %b expected 0", bus.irq); else n_pass++;
        peek(32'hFFFF1012, d, h);
        n_checks++; if (d !== 16'h0000) $display("FAIL abort_pend: got %h expected 0000", d); else n_pass++;
        n_checks++; if (bus.intAddr !== 32'h0) $display("FAIL abort_intAddr: got %h expected 0", bus.intAddr); else n_pass++;
        rst = 1'b0;
        write_reg(32'hFFFF1010, 16'h00FF);
        tick();
        tick();
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL held_src_irq: got %b expected 0", bus.irq); else n_pass++;
        peek(32'hFFFF1012, d, h);
        n_checks++; if (d !== 16'h0000) $display("FAIL held_src_pend: got %h expected 0000", d); else n_pass++;
        bus.src = '0;
        tick();
    endtask

    task automatic test_swtrig();
        logic [15:0] d;
        logic        h;
        write_reg(32'hFFFF1010, 16'h0080);
`ifdef INTC_SWTRIG_EN
        bus.memAddr  = 32'hFFFF1013;
        bus.memWrite = 16'h0080;
        bus.memWE    = 1'b1;
        #1;
        n_checks++; if (bus.regHit !== 1'b1 || bus.regRead !== 16'h0) $display("FAIL swtrig_decode: got %b/%h expected 1/0000", bus.regHit, bus.regRead); else n_pass++;
        tick();
        bus.memWE = 1'b0;
        peek(32'hFFFF1012, d, h);
        n_checks++; if (d !== 16'h0080) $display("FAIL swtrig_pend: got %h expected 0080", d); else n_pass++;
        tick();
        n_checks++; if (bus.irq !== 1'b1) $display("FAIL swtrig_irq: got %b expected 1", bus.irq); else n_pass++;
        n_checks++; if (bus.intAddr[7:0] !== 8'h1C) $display("FAIL swtrig_intAddr: got %h expected 1C", bus.intAddr[7:0]); else n_pass++;
        ack_and_drain();
`else
        peek(32'hFFFF1013, d, h);
        n_checks++; if (h !== 1'b0 || d !== 16'h0) $display("FAIL swtrig_nodecode: got %b/%h expected 0/0000", h, d); else n_pass++;
        write_reg(32'hFFFF1013, 16'h0080);
        tick();
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL swtrig_absent_irq: got %b expected 0", bus.irq); else n_pass++;
        peek(32'hFFFF1012, d, h);
        n_checks++; if (d !== 16'h0000) $display("FAIL swtrig_absent_pend: got %h expected 0000", d); else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [7:0]  s;
        logic        ack;
        logic        we;
        logic [31:0] a;
        logic [15:0] wd;
        logic [31:0] addrs [6];
        addrs[0] = 32'hFFFF1010;
        addrs[1] = 32'hFFFF1011;
        addrs[2] = 32'hFFFF1012;
        addrs[3] = 32'hFFFF1013;
        addrs[4] = 32'hFFFF1014;
        addrs[5] = 32'h0000_1010;
        rst     = 1'b1;
        bus.src = 8'($urandom);
        tick();
        model_reset(bus.src);
        rst = 1'b0;
        for (int unsigned n = 0; n < 500; n++) begin
            s   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : bus.src;
            ack = ($urandom_range(0, 2) == 0);
            we  = ($urandom_range(0, 7) == 0);
            a   = addrs[$urandom_range(0, 5)];
            wd  = 16'($urandom);
            bus.src        = s;
            bus.turnOffIRQ = ack;
            bus.memWE      = we;
            bus.memAddr    = a;
            bus.memWrite   = wd;
            tick();
            model_step(s, ack, we, a, wd);
            n_checks++; if (bus.irq !== (m_phase == 1)) $display("FAIL rand_irq@%0d: got %b expected %b", n, bus.irq, (m_phase == 1)); else n_pass++;
            n_checks++; if (bus.intAddr !== m_intaddr) $display("FAIL rand_intAddr@%0d: got %h expected %h", n, bus.intAddr, m_intaddr); else n_pass++;
            n_checks++; if (bus.intData !== m_intdata) $display("FAIL rand_intData@%0d: got %h expected %h", n, bus.intData, m_intdata); else n_pass++;
            n_checks++; if (bus.regRead !== m_read(a)) $display("FAIL rand_regRead@%0d: got %h expected %h", n, bus.regRead, m_read(a)); else n_pass++;
            n_checks++; if (bus.regHit !== m_hit(a)) $display("FAIL rand_regHit@%0d: got %b expected %b", n, bus.regHit, m_hit(a)); else n_pass++;
        end
        bus.memWE      = 1'b0;
        bus.turnOffIRQ = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        rst            = 1'b1;
        bus.src        = '0;
        bus.turnOffIRQ = 1'b0;
        bus.memAddr    = '0;
        bus.memWrite   = '0;
        bus.memWE      = 1'b0;
        test_reset();
        test_basic();
        test_simultaneous();
        test_mask();
        test_ack_rules();
        test_reset_abort();
        test_swtrig();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter NSRC, default 8, number of interrupt sources (fixed 8 in this revision; index width 3).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port src  input  8  raw interrupt source lines, synchronous to clk.
REQ-005 SHALL have port irq  output  1  interrupt request to CPU core.
REQ-006 SHALL have port turnOffIRQ  input  1  acknowledge pulse from CPU core.
REQ-007 SHALL have port intAddr  output  32  handler address of the selected source.
REQ-008 SHALL have port intData  output  16  cause word of the selected source.
REQ-009 SHALL have ports memAddr (input, 32), memWrite (input, 16), memWE (input, 1), the CPU bus write side.
REQ-010 SHALL have ports regRead (output, 16, readback data) and regHit (output, 1, memAddr decodes to a controller register).

Function
REQ-011 SHALL detect rising edges on each src bit (registered previous value) and set the matching pending bit.
REQ-012 SHALL hold registers: MASK at 32'hFFFF1010 (reset 0), VBASE at 32'hFFFF1011 (reset 16'h0000); write when memWE and address match, same cycle effect next edge.
REQ-013 SHALL drive regHit=1 for 32'hFFFF1010..32'hFFFF1012; regRead = MASK, VBASE, or {8'h00, pending} respectively; 0 otherwise.
REQ-014 SHALL select the lowest-index bit of (pending & MASK) as winner; no winner means no request.
REQ-015 SHALL run FSM IDLE -> REQ -> ACK -> IDLE.
REQ-016 IDLE: if winner exists, latch index sel and pending snapshot, go REQ next cycle; irq=0.
REQ-017 REQ: irq=1; intAddr = {VBASE, 11'b0, sel, 2'b00}; intData = {5'b0, sel, snapshot}; both stable for entire REQ; MASK writes during REQ do not withdraw the request.
REQ-018 REQ with turnOffIRQ=1: clear pending[sel], go ACK; turnOffIRQ in IDLE or ACK SHALL be ignored.
REQ-019 ACK: irq=0 for exactly one cycle, then IDLE (re-arbitration); minimum 2 cycles between consecutive irq assertions.
REQ-020 SHALL give set priority over clear: new edge on src[sel] in the clearing cycle leaves pending[sel]=1.
REQ-021 Latency: src edge at cycle t -> pending at t+1 -> irq=1 at t+2 when IDLE and unmasked.
REQ-022 intAddr/intData SHALL hold last latched value outside REQ.

Reset
REQ-023 On rst: state=IDLE, irq=0, pending=0, MASK=0, VBASE=0, sel=0, snapshot=0, edge history=current src (no spurious edge after reset), intAddr=0, intData=0.
REQ-024 rst asserted in REQ or ACK SHALL abort: irq=0 next cycle, pending lost.

Configuration
REQ-025 Macro INTC_SWTRIG_EN defined: register SWTRIG at 32'hFFFF1013, write-only, each 1 bit ORs into pending that cycle; regHit covers 32'hFFFF1013, regRead=0 there.
REQ-026 INTC_SWTRIG_EN undefined: address 32'hFFFF1013 not decoded, regHit=0, no software-set path.

Structure
REQ-027 Register addresses, FSM state codes and vector format widths SHALL live in the shared constants package alongside core constants.
REQ-028 SHALL instantiate one sub-module intc_prio_enc (8-bit request in, 3-bit index plus valid out, combinational).

Verification
REQ-029 MASK=8'hFF, VBASE=16'h4000, edge on src[2] -> irq=1 two cycles later, intAddr=32'h40000008, intData=16'h0204.
REQ-030 Simultaneous edges src[5], src[1] -> first service index 1; after ack plus one ACK cycle second irq with index 5, intData low byte 8'h20.
REQ-031 MASK=8'h00, edge src[3] -> irq stays 0, regRead at FFFF1012 = 16'h0008; write MASK=8'h08 -> irq=1 two cycles later.
REQ-032 turnOffIRQ in IDLE -> no state change; new src[sel] edge in clearing cycle -> pending[sel] stays 1, re-request after ACK.
REQ-033 rst in REQ -> irq=0 and pending=0 next cycle; src held high across reset -> no irq.
REQ-034 With INTC_SWTRIG_EN, write 16'h0080 to FFFF1013, MASK=8'h80 -> irq, intAddr low byte 8'h1C; without macro, regHit=0 at that address.
